// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory handshake, redirect and issue-side signals.
// master = fetch unit, slave = memory / execute environment.
interface instruction_fetch_unit_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_data;
  logic        stall;
  logic        jmp_take;
  logic [15:0] jmp_target;
  logic        valid;
  logic [15:0] instr;
  logic [3:0]  i0_3;
  logic [3:0]  i4_7;
  logic [3:0]  i8_11;
  logic [3:0]  i12_15;
  logic [15:0] instr_pc;
  logic        fault;

  modport master (
    output imem_req, imem_addr, valid, instr, i0_3, i4_7, i8_11, i12_15, instr_pc, fault,
    input  imem_ack, imem_data, stall, jmp_take, jmp_target
  );

  modport slave (
    input  imem_req, imem_addr, valid, instr, i0_3, i4_7, i8_11, i12_15, instr_pc, fault,
    output imem_ack, imem_data, stall, jmp_take, jmp_target
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Single-outstanding instruction fetcher with redirect flush and sticky memory-timeout halt.
// Latency 1 cycle ack->valid; stall holds the issued word and blocks any new request.
module instruction_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          TIMEOUT  = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  instruction_fetch_unit_if.master  bus
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_ISSUE = 2'd1,
    S_FLUSH = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  state_t      state_nxt;
  logic [15:0] pc;
  logic [15:0] instr_q;
  logic [15:0] instr_pc_q;
  logic        valid_q;
  logic        fault_q;
  logic [7:0]  wait_cnt;
  logic        timed_out;

  assign timed_out = (wait_cnt == WAIT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  // Redirect wins over ack, stall and timeout in every live state.
  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH: begin
        if (bus.jmp_take)      state_nxt = S_FLUSH;
        else if (bus.imem_ack) state_nxt = S_ISSUE;
        else if (timed_out)    state_nxt = S_HALT;
      end
      S_ISSUE: begin
        if (bus.jmp_take)      state_nxt = S_FLUSH;
        else if (!bus.stall)   state_nxt = S_FETCH;
      end
      S_FLUSH: begin
        if (!bus.jmp_take)     state_nxt = S_FETCH;
      end
      default:                 state_nxt = S_HALT;
    endcase
  end

  // Request is masked during reset so an in-flight fetch is abandoned immediately.
  always_comb begin
    bus.imem_req = 1'b0;
    if (!rst && state == S_FETCH) bus.imem_req = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= RESET_PC;
      instr_q    <= 16'h0000;
      instr_pc_q <= 16'h0000;
      valid_q    <= 1'b0;
      fault_q    <= 1'b0;
      wait_cnt   <= 8'd0;
    end else begin
      case (state)
        S_FETCH: begin
          if (bus.jmp_take) begin
            pc       <= bus.jmp_target;
            valid_q  <= 1'b0;
            wait_cnt <= 8'd0;
          end else if (bus.imem_ack) begin
            instr_q    <= bus.imem_data;
            instr_pc_q <= pc;
            pc         <= pc + 16'd1;
            valid_q    <= 1'b1;
            wait_cnt   <= 8'd0;
          end else if (timed_out) begin
            fault_q  <= 1'b1;
            valid_q  <= 1'b0;
            wait_cnt <= 8'd0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        S_ISSUE: begin
          if (bus.jmp_take) begin
            pc      <= bus.jmp_target;
            valid_q <= 1'b0;
          end else if (!bus.stall) begin
            valid_q <= 1'b0;
          end
        end
        S_FLUSH: begin
          if (bus.jmp_take) pc <= bus.jmp_target;
        end
        default: begin
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_addr = pc;
  assign bus.valid     = valid_q;
  assign bus.instr     = instr_q;
  assign bus.instr_pc  = instr_pc_q;
  assign bus.fault     = fault_q;
  assign bus.i0_3      = instr_q[3:0];
  assign bus.i4_7      = instr_q[7:4];
  assign bus.i8_11     = instr_q[11:8];
  assign bus.i12_15    = instr_q[15:12];

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed and random stimulus for instruction_fetch_unit against a transaction-level model.
module tb_instruction_fetch_unit;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instruction_fetch_unit_if bus();

  instruction_fetch_unit #(.RESET_PC(16'h0000), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: an instruction is either held, a flush bubble is pending, the unit has
  // faulted, or else it is fetching.
  logic [15:0] m_pc, m_instr, m_ipc;
  bit          m_valid, m_fault;
  int          m_flush, m_waited;

  function automatic bit m_fetching();
    return !m_fault && !m_valid && (m_flush == 0);
  endfunction

  task automatic m_reset();
    m_pc = 16'h0000; m_instr = 16'h0000; m_ipc = 16'h0000;
    m_valid = 1'b0; m_fault = 1'b0; m_flush = 0; m_waited = 0;
  endtask

  task automatic model_edge();
    if (rst) begin
      m_reset();
    end else if (m_fault) begin
      m_fault = 1'b1;
    end else if (bus.jmp_take) begin
      m_pc = bus.jmp_target; m_valid = 1'b0; m_flush = 1; m_waited = 0;
    end else if (m_flush > 0) begin
      m_flush = 0;
    end else if (m_valid) begin
      if (!bus.stall) m_valid = 1'b0;
    end else if (bus.imem_ack) begin
      m_instr = bus.imem_data; m_ipc = m_pc; m_pc = m_pc + 16'd1;
      m_valid = 1'b1; m_waited = 0;
    end else begin
      m_waited = m_waited + 1;
      if (m_waited >= TO) begin
        m_fault = 1'b1; m_waited = 0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    bit exp_req;
    exp_req = !rst && m_fetching();
    chk("imem_req", 16'(bus.imem_req), 16'(exp_req));
    if (exp_req) chk("imem_addr", bus.imem_addr, m_pc);
    chk("valid", 16'(bus.valid), 16'(m_valid));
    chk("fault", 16'(bus.fault), 16'(m_fault));
    chk("instr", bus.instr, m_instr);
    chk("instr_pc", bus.instr_pc, m_ipc);
    chk("i0_3", 16'(bus.i0_3), m_instr % 16'd16);
    chk("i4_7", 16'(bus.i4_7), (m_instr / 16'd16) % 16'd16);
    chk("i8_11", 16'(bus.i8_11), (m_instr / 16'd256) % 16'd16);
    chk("i12_15", 16'(bus.i12_15), m_instr / 16'd4096);
  endtask

  task automatic step(input bit r, input bit a, input logic [15:0] d,
                      input bit s, input bit j, input logic [15:0] t);
    rst            = r;
    bus.imem_ack   = a;
    bus.imem_data  = d;
    bus.stall      = s;
    bus.jmp_take   = j;
    bus.jmp_target = t;
    #1;
    check_model();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
  endtask

  initial begin
    rst = 1'b1;
    bus.imem_ack = 1'b0; bus.imem_data = 16'h0000; bus.stall = 1'b0;
    bus.jmp_take = 1'b0; bus.jmp_target = 16'h0000;
    m_reset();
    @(posedge clk);
    @(negedge clk);

    // Reset state, then first fetch and decode of the returned word
    step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    chk("reset_req", 16'(bus.imem_req), 16'h0000);
    chk("reset_valid", 16'(bus.valid), 16'h0000);
    idle();
    step(1'b0, 1'b1, 16'hA3C1, 1'b0, 1'b0, 16'h0000);
    chk("first_valid", 16'(bus.valid), 16'h0001);
    chk("first_i0_3", 16'(bus.i0_3), 16'h0001);
    chk("first_i4_7", 16'(bus.i4_7), 16'h000C);
    chk("first_i8_11", 16'(bus.i8_11), 16'h0003);
    chk("first_i12_15", 16'(bus.i12_15), 16'h000A);
    chk("first_pc", bus.instr_pc, 16'h0000);
    chk("issue_no_req", 16'(bus.imem_req), 16'h0000);
    idle();
    chk("next_addr", bus.imem_addr, 16'h0001);
    chk("next_req", 16'(bus.imem_req), 16'h0001);

    // Stall holds the issued word
    step(1'b0, 1'b1, 16'h1234, 1'b0, 1'b0, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
      chk("stall_instr", bus.instr, 16'h1234);
      chk("stall_pc", bus.instr_pc, 16'h0001);
      chk("stall_valid", 16'(bus.valid), 16'h0001);
      chk("stall_req", 16'(bus.imem_req), 16'h0000);
    end
    idle();
    chk("resume_req", 16'(bus.imem_req), 16'h0001);
    chk("resume_addr", bus.imem_addr, 16'h0002);

    // Redirect coincident with ack discards the data
    step(1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b1, 16'h0040);
    chk("jmp_valid", 16'(bus.valid), 16'h0000);
    chk("jmp_flush_req", 16'(bus.imem_req), 16'h0000);
    idle();
    chk("jmp_req", 16'(bus.imem_req), 16'h0001);
    chk("jmp_addr", bus.imem_addr, 16'h0040);

    // pc wraparound
    step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'hFFFF);
    idle();
    chk("wrap_addr_top", bus.imem_addr, 16'hFFFF);
    step(1'b0, 1'b1, 16'h5A5A, 1'b0, 1'b0, 16'h0000);
    chk("wrap_instr_pc", bus.instr_pc, 16'hFFFF);
    idle();
    chk("wrap_addr_zero", bus.imem_addr, 16'h0000);

    // Random traffic, including resets mid-request and timeouts
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 9) < 6), 16'($urandom),
           1'($urandom_range(0, 1)), ($urandom_range(0, 11) == 0), 16'($urandom));
    end

    // Timeout, halt ignores redirect and ack, reset recovers
    step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    for (int i = 0; i < TO - 1; i++) idle();
    chk("pre_timeout_fault", 16'(bus.fault), 16'h0000);
    idle();
    chk("timeout_fault", 16'(bus.fault), 16'h0001);
    chk("timeout_req", 16'(bus.imem_req), 16'h0000);
    chk("timeout_valid", 16'(bus.valid), 16'h0000);
    step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h1234);
    step(1'b0, 1'b1, 16'hBEEF, 1'b0, 1'b0, 16'h0000);
    chk("halt_fault", 16'(bus.fault), 16'h0001);
    chk("halt_req", 16'(bus.imem_req), 16'h0000);
    chk("halt_valid", 16'(bus.valid), 16'h0000);
    step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    chk("recover_fault", 16'(bus.fault), 16'h0000);
    idle();
    chk("recover_req", 16'(bus.imem_req), 16'h0001);
    chk("recover_addr", bus.imem_addr, 16'h0000);

    // Reset mid-request, late ack answers the fresh RESET_PC request
    step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    step(1'b0, 1'b1, 16'h0BEE, 1'b0, 1'b0, 16'h0000);
    chk("late_ack_valid", 16'(bus.valid), 16'h0001);
    chk("late_ack_pc", bus.instr_pc, 16'h0000);
    chk("late_ack_instr", bus.instr, 16'h0BEE);
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, the address fetched first after reset.
REQ-002 SHALL have parameter TIMEOUT, default 255, the maximum cycles to wait for imem_ack before faulting.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port imem_req  output  1  instruction memory read request.
REQ-006 SHALL have port imem_addr  output  16  word address of the outstanding request.
REQ-007 SHALL have port imem_ack  input  1  memory has returned data on imem_data this cycle.
REQ-008 SHALL have port imem_data  input  16  instruction word, valid when imem_ack=1.
REQ-009 SHALL have port stall  input  1  register fetch unit cannot accept the issued instruction this cycle.
REQ-010 SHALL have port jmp_take  input  1  execute stage redirects the fetch stream.
REQ-011 SHALL have port jmp_target  input  16  redirect address, sampled when jmp_take=1.
REQ-012 SHALL have port valid  output  1  instr and its fields hold a live instruction.
REQ-013 SHALL have port instr  output  16  registered instruction word.
REQ-014 SHALL have ports i0_3, i4_7, i8_11, i12_15  output  4 each  instr bits [3:0], [7:4], [11:8], [15:12], wired directly from instr.
REQ-015 SHALL have port instr_pc  output  16  address instr was fetched from.
REQ-016 SHALL have port fault  output  1  sticky memory-timeout indication.

Function
REQ-017 SHALL implement states FETCH, ISSUE, FLUSH, HALT, encoded in a registered state variable.
REQ-018 SHALL hold a 16-bit pc register; pc increments modulo 2^16 (16'hFFFF -> 16'h0000, no flag).
REQ-019 FETCH: imem_req=1, imem_addr=pc; imem_addr SHALL stay stable while imem_req=1 until imem_ack.
REQ-020 FETCH with imem_ack=1 and jmp_take=0: instr<=imem_data, instr_pc<=pc, pc<=pc+1, valid<=1, go ISSUE; latency ack-to-valid is 1 cycle.
REQ-021 ISSUE: imem_req=0, valid=1; stall=1 holds instr, instr_pc, valid unchanged; stall=0 consumes the instruction, valid<=0, go FETCH.
REQ-022 jmp_take=1 in FETCH, ISSUE or FLUSH SHALL set pc<=jmp_target, valid<=0, go FLUSH, overriding stall and imem_ack (returned data discarded).
REQ-023 FLUSH: imem_req=0 for exactly one cycle, then FETCH at the new pc; a further jmp_take in FLUSH reloads pc and stays in FLUSH one more cycle.
REQ-024 SHALL count consecutive FETCH cycles without imem_ack in an 8-bit wait counter, cleared on leaving FETCH or on ack.
REQ-025 When the wait counter reaches TIMEOUT with no ack, SHALL set fault<=1, valid<=0, go HALT.
REQ-026 HALT: imem_req=0, valid=0, fault=1, inputs ignored including jmp_take; exit only via rst.
REQ-027 imem_ack while imem_req=0 SHALL be ignored.
REQ-028 Throughput SHALL be at most one instruction per two cycles; no request is issued while valid=1.

Reset
REQ-029 rst=1 at a clock edge SHALL force state=FETCH, pc=RESET_PC, instr=0, instr_pc=0, valid=0, fault=0, wait counter=0, regardless of state including HALT.
REQ-030 imem_req SHALL be 0 during the cycle rst is high and SHALL rise in the first cycle after rst falls.
REQ-031 rst mid-request SHALL abandon the request; a late imem_ack arriving after rst falls SHALL be taken as response to the new RESET_PC request.

Verification
REQ-032 Reset release, memory acks 16'hA3C1 one cycle after req -> imem_addr=16'h0000, valid=1 with i0_3=1, i4_7=C, i8_11=3, i12_15=A, instr_pc=0, next request addr 16'h0001.
REQ-033 stall held 3 cycles in ISSUE -> instr, instr_pc, valid unchanged for 3 cycles, imem_req=0 throughout; fetch resumes the cycle after stall falls.
REQ-034 jmp_take with jmp_target=16'h0040 coincident with imem_ack of 16'hFFFF -> data discarded, valid stays 0, one cycle req=0, then imem_addr=16'h0040.
REQ-035 pc=16'hFFFF fetched -> instr_pc=16'hFFFF, next imem_addr=16'h0000.
REQ-036 No ack for TIMEOUT=4 cycles -> fault=1, req=0, valid=0; jmp_take ignored; rst returns to FETCH at RESET_PC with fault=0.
